idct_row_pipe: RTL and testbench

//  Pipelined, parametrised 8-point 1-D IDCT row stage. It replaces the combinational

---
 rtl/idct_row_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_idct_row_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_row_pipe.sv
// idct_row_pipe: three-stage pipelined 8-point 1-D IDCT row stage.
//   S1 registers the even/odd partial products, S2 the butterflied
//   accumulators, and S3 the rounded, range-fitted output samples.
//   Each stage has a valid/ready handshake, and bubbles collapse.
//   Each output row is tagged with its index in the 8x8 block.

// Per-lane rounding, arithmetic shift and saturate/wrap for one accumulator.
module idct_row_pipe_lane #(
    parameter int ACC_W      = 22,
    parameter int OUT_W      = 9,
    parameter int SHIFT      = 7,
    parameter int ROUND_MODE = 2,
    parameter int SATURATE   = 1
) (
    input  logic signed [ACC_W-1:0] i_y,
    output logic        [OUT_W-1:0] o_q,
    output logic                    o_ovf
);
    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] HALF_M1 = HALF - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MAXV    = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV    = ~MAXV;

    logic signed [ACC_W-1:0] w_bias;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_sh;

    // Bias for the rounding mode, shift, then clamp or wrap into OUT_W.
    // Ties go away from zero: for negative values the bias is one short of
    // half, so an exact .5 floors downward and a fraction past .5 still
    // rounds to nearest.
    always_comb begin
        w_bias = '0;
        if (ROUND_MODE == 1)
            w_bias = HALF;
        else if (ROUND_MODE == 2)
            w_bias = i_y[ACC_W-1] ? HALF_M1 : HALF;
        w_sum = i_y + w_bias;
        w_sh  = w_sum >>> SHIFT;
        o_ovf = (w_sh > MAXV) || (w_sh < MINV);
        o_q   = w_sh[OUT_W-1:0];
        if (SATURATE != 0) begin
            if (w_sh > MAXV)
                o_q = MAXV[OUT_W-1:0];
            else if (w_sh < MINV)
                o_q = MINV[OUT_W-1:0];
        end
    end
endmodule

module idct_row_pipe #(
    parameter int IN_W       = 12,
    parameter int OUT_W      = 9,
    parameter int SHIFT      = 7,
    parameter int ROUND_MODE = 2,
    parameter int SATURATE   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*IN_W-1:0]    in_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   out_row,
    output logic [2:0]           out_idx,
    output logic                 out_last,
    output logic                 sat_flag,
    input  logic                 sat_clr
);
    localparam int ACC_W  = IN_W + 10;
    localparam int STAGES = 3;

    // Constant multiplies as shift-add. The values are two's complement
    // modulo 2^ACC_W. ACC_W has headroom for the largest row, so the
    // results are exact.
    function automatic logic [ACC_W-1:0] mul_c1(input logic [ACC_W-1:0] x);  // 63
        return (x << 6) - x;
    endfunction
    function automatic logic [ACC_W-1:0] mul_c2(input logic [ACC_W-1:0] x);  // 59
        return (x << 6) - (x << 2) - x;
    endfunction
    function automatic logic [ACC_W-1:0] mul_c3(input logic [ACC_W-1:0] x);  // 53
        return (x << 5) + (x << 4) + (x << 2) + x;
    endfunction
    function automatic logic [ACC_W-1:0] mul_c4(input logic [ACC_W-1:0] x);  // 45
        return (x << 5) + (x << 3) + (x << 2) + x;
    endfunction
    function automatic logic [ACC_W-1:0] mul_c5(input logic [ACC_W-1:0] x);  // 36
        return (x << 5) + (x << 2);
    endfunction
    function automatic logic [ACC_W-1:0] mul_c6(input logic [ACC_W-1:0] x);  // 24
        return (x << 4) + (x << 3);
    endfunction
    function automatic logic [ACC_W-1:0] mul_c7(input logic [ACC_W-1:0] x);  // 12
        return (x << 3) + (x << 2);
    endfunction

    // Handshake chain: a stage loads when empty or when its content leaves.
    logic [STAGES:1] r_vld_pipe;
    logic            w_rdy1, w_rdy2, w_rdy3;
    logic            w_ld1, w_ld2, w_ld3, w_out_hs;

    assign w_rdy3   = !r_vld_pipe[3] || out_ready;
    assign w_rdy2   = !r_vld_pipe[2] || w_rdy3;
    assign w_rdy1   = !r_vld_pipe[1] || w_rdy2;
    assign w_ld1    = in_valid && w_rdy1;
    assign w_ld2    = r_vld_pipe[1] && w_rdy2;
    assign w_ld3    = r_vld_pipe[2] && w_rdy3;
    assign w_out_hs = r_vld_pipe[3] && out_ready;

    // Sign-extended coefficients; x0 sits in the MSBs of in_row.
    logic [7:0][ACC_W-1:0] w_x;
    for (genvar g = 0; g < 8; g++) begin : g_x
        assign w_x[g] = {{(ACC_W-IN_W){in_row[(8-g)*IN_W-1]}}, in_row[(7-g)*IN_W +: IN_W]};
    end

    // S1 combinational: even and odd partial sums.
    logic [3:0][ACC_W-1:0] w_e, w_o, r_e, r_o;
    always_comb begin
        w_e[0] = mul_c4(w_x[0] + w_x[4]);
        w_e[1] = mul_c4(w_x[0] - w_x[4]);
        w_e[2] = mul_c2(w_x[2]) + mul_c6(w_x[6]);
        w_e[3] = mul_c6(w_x[2]) - mul_c2(w_x[6]);
        w_o[0] = mul_c1(w_x[1]) + mul_c3(w_x[3]) + mul_c5(w_x[5]) + mul_c7(w_x[7]);
        w_o[1] = mul_c3(w_x[1]) - mul_c7(w_x[3]) - mul_c1(w_x[5]) - mul_c5(w_x[7]);
        w_o[2] = mul_c5(w_x[1]) - mul_c1(w_x[3]) + mul_c7(w_x[5]) + mul_c3(w_x[7]);
        w_o[3] = mul_c7(w_x[1]) - mul_c5(w_x[3]) + mul_c3(w_x[5]) - mul_c1(w_x[7]);
    end

    // S2 combinational: even butterfly, then the output butterfly.
    logic [3:0][ACC_W-1:0] w_t;
    logic [7:0][ACC_W-1:0] w_y, r_y;
    always_comb begin
        w_t[0] = r_e[0] + r_e[2];
        w_t[1] = r_e[1] + r_e[3];
        w_t[2] = r_e[1] - r_e[3];
        w_t[3] = r_e[0] - r_e[2];
        for (int i = 0; i < 4; i++) begin
            w_y[i]   = w_t[i] + r_o[i];
            w_y[7-i] = w_t[i] - r_o[i];
        end
    end

    // S3 combinational: one rounding/range lane per sample. y0 goes to the MSBs.
    logic [7:0]              w_ovf;
    logic [8*OUT_W-1:0]      w_row;
    for (genvar g = 0; g < 8; g++) begin : g_lane
        idct_row_pipe_lane #(
            .ACC_W     (ACC_W),
            .OUT_W     (OUT_W),
            .SHIFT     (SHIFT),
            .ROUND_MODE(ROUND_MODE),
            .SATURATE  (SATURATE)
        ) u_lane (
            .i_y  ($signed(r_y[g])),
            .o_q  (w_row[(7-g)*OUT_W +: OUT_W]),
            .o_ovf(w_ovf[g])
        );
    end

    // Stage valid bits. Reset discards any row in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
        end else begin
            if (w_rdy1) r_vld_pipe[1] <= in_valid;
            if (w_rdy2) r_vld_pipe[2] <= r_vld_pipe[1];
            if (w_rdy3) r_vld_pipe[3] <= r_vld_pipe[2];
        end
    end

    // S1/S2 datapath registers. The valid bits cover them, so they have no reset.
    always_ff @(posedge clk) begin
        if (w_ld1) begin
            r_e <= w_e;
            r_o <= w_o;
        end
        if (w_ld2)
            r_y <= w_y;
    end

    // S3 output register. It holds while the downstream stalls.
    logic [8*OUT_W-1:0] r_row;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_row <= '0;
        else if (w_ld3)
            r_row <= w_row;
    end

    // Sticky range flag. A new out-of-range row wins over a clear in the same cycle.
    logic r_sat;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sat <= 1'b0;
        else if (w_ld3 && (|w_ovf))
            r_sat <= 1'b1;
        else if (sat_clr)
            r_sat <= 1'b0;
    end

    // Row-in-block counter. It advances on each output handshake and wraps 7 to 0.
    logic [2:0] r_idx;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_idx <= 3'd0;
        else if (w_out_hs)
            r_idx <= r_idx + 3'd1;
    end

    assign in_ready  = w_rdy1;
    assign out_valid = r_vld_pipe[3];
    assign out_row   = r_row;
    assign out_idx   = r_idx;
    assign out_last  = r_vld_pipe[3] && (r_idx == 3'd7);
    assign sat_flag  = r_sat;
endmodule

// File: tb/tb_idct_row_pipe.sv
// Scoreboard bench for idct_row_pipe. Three instances share the stimulus:
//   d0: round-half-away, saturate  d1: floor, wrap  d2: round-half-up, saturate
module tb_idct_row_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sat_clr = 1'b0;
    logic [95:0] in_row = '0;

    logic        irdy  [3];
    logic        ov    [3];
    logic [71:0] orow  [3];
    logic [2:0]  oidx  [3];
    logic        olast [3];
    logic        osat  [3];

    always #5 clk = ~clk;

    idct_row_pipe #(.ROUND_MODE(2), .SATURATE(1)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]), .in_row(in_row),
        .out_valid(ov[0]), .out_ready(out_ready), .out_row(orow[0]), .out_idx(oidx[0]),
        .out_last(olast[0]), .sat_flag(osat[0]), .sat_clr(sat_clr));
    idct_row_pipe #(.ROUND_MODE(0), .SATURATE(0)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]), .in_row(in_row),
        .out_valid(ov[1]), .out_ready(out_ready), .out_row(orow[1]), .out_idx(oidx[1]),
        .out_last(olast[1]), .sat_flag(osat[1]), .sat_clr(sat_clr));
    idct_row_pipe #(.ROUND_MODE(1), .SATURATE(1)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[2]), .in_row(in_row),
        .out_valid(ov[2]), .out_ready(out_ready), .out_row(orow[2]), .out_idx(oidx[2]),
        .out_last(olast[2]), .sat_flag(osat[2]), .sat_clr(sat_clr));

    int nchk = 0;
    int nerr = 0;

    function automatic void chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Reference: direct cosine-matrix form, y_n = sum_k x_k * C[(2n+1)k].
    localparam int CT [8] = '{0, 63, 59, 53, 45, 36, 24, 12};

    function automatic int cosv(input int m0);
        int m = m0 % 32;
        if (m > 16) m = 32 - m;
        if (m == 8) return 0;
        if (m < 8)  return CT[m];
        return -CT[16 - m];
    endfunction

    function automatic logic [71:0] model(input logic [95:0] r, input int mode, input int sat);
        logic [71:0] res = '0;
        for (int n = 0; n < 8; n++) begin
            int y = 0;
            int q;
            for (int k = 0; k < 8; k++) begin
                logic [11:0] f = r[(7-k)*12 +: 12];
                int xv = int'($signed(f));
                y += xv * ((k == 0) ? CT[4] : cosv((2*n + 1) * k));
            end
            case (mode)
                0:       q = y >>> 7;
                1:       q = (y + 64) >>> 7;
                default: q = (y >= 0) ? ((y + 64) >>> 7) : -((64 - y) >>> 7);
            endcase
            if (sat != 0) begin
                if (q > 255) q = 255;
                else if (q < -256) q = -256;
            end
            res[(7-n)*9 +: 9] = q[8:0];
        end
        return res;
    endfunction

    function automatic logic [71:0] rep(input int v);
        logic [8:0] b = v[8:0];
        return {8{b}};
    endfunction

    function automatic logic [95:0] dc(input int v);
        logic [11:0] b = v[11:0];
        return {b, 84'd0};
    endfunction

    function automatic logic [95:0] pat(input int s);
        logic [95:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            int v = ((s*173 + i*311 + s*i*29) % 1536) - 768;
            r[(7-i)*12 +: 12] = v[11:0];
        end
        return r;
    endfunction

    logic [71:0] q0[$], q1[$], q2[$];

    // Present one row, wait (bounded) for acceptance, then record expectations.
    task automatic send(input logic [95:0] r, input logic [71:0] ea, input logic [71:0] eb,
                        input logic [71:0] ec);
        int n = 0;
        in_valid = 1'b1;
        in_row   = r;
        @(negedge clk);
        while (!irdy[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!irdy[0]) begin
            nchk++; nerr++;
            $display("FAIL accept_timeout: in_ready still %b, required 1", irdy[0]);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        q0.push_back(ea);
        q1.push_back(eb);
        q2.push_back(ec);
    endtask

    task automatic sendm(input logic [95:0] r);
        send(r, model(r, 2, 1), model(r, 0, 0), model(r, 1, 1));
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_q0", 72'(q0.size()), 72'd0);
        chk("drain_q1", 72'(q1.size()), 72'd0);
        chk("drain_q2", 72'(q2.size()), 72'd0);
    endtask

    // Monitor: pop and compare on every output handshake; check hold stability.
    logic        hold [3] = '{1'b0, 1'b0, 1'b0};
    logic [71:0] prow [3];
    logic [2:0]  pidx [3];
    int          eidx [3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                hold[d] = 1'b0;
                eidx[d] = 0;
            end else begin
                if (hold[d]) begin
                    chk($sformatf("hold_valid_d%0d", d), 72'(ov[d]), 72'd1);
                    chk($sformatf("hold_row_d%0d", d), orow[d], prow[d]);
                    chk($sformatf("hold_idx_d%0d", d), 72'(oidx[d]), 72'(pidx[d]));
                end
                if (ov[d] && out_ready) begin
                    logic [71:0] e;
                    logic        got;
                    got = 1'b0;
                    e   = '0;
                    if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                    else if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                    else if (d == 2 && q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                    if (!got) begin
                        nchk++; nerr++;
                        $display("FAIL unexpected_row_d%0d: got row %h, required none", d, orow[d]);
                    end else begin
                        chk($sformatf("row_d%0d", d), orow[d], e);
                        chk($sformatf("idx_d%0d", d), 72'(oidx[d]), 72'(eidx[d][2:0]));
                        chk($sformatf("last_d%0d", d), 72'(olast[d]), 72'(eidx[d] == 7));
                    end
                    eidx[d] = (eidx[d] + 1) % 8;
                end
                hold[d] = ov[d] && !out_ready;
                prow[d] = orow[d];
                pidx[d] = oidx[d];
            end
        end
    end

    // Fill tracker: with a stalled output, in_ready must fall exactly when 3 rows are held.
    int   acc_n = 0, del_n = 0, ir_low = 0;
    logic bp_chk = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            acc_n = 0;
            del_n = 0;
        end else begin
            if (bp_chk) begin
                chk("in_ready_vs_fill", 72'(irdy[0]), 72'(out_ready || (acc_n - del_n) < 3));
                if (!irdy[0]) ir_low++;
            end
            if (in_valid && irdy[0]) acc_n++;
            if (ov[0] && out_ready) del_n++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    int lat, run;

    initial begin
        // Reset state
        #22;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_valid_d%0d", d), 72'(ov[d]), 72'd0);
            chk($sformatf("rst_idx_d%0d", d), 72'(oidx[d]), 72'd0);
            chk($sformatf("rst_row_d%0d", d), orow[d], 72'd0);
            chk($sformatf("rst_sat_d%0d", d), 72'(osat[d]), 72'd0);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("in_ready_idle", 72'(irdy[0]), 72'd1);
        @(posedge clk); #1;

        // DC rows, hand-computed: 45*64/128 = 22.5
        send(dc(64),  rep(23),  rep(22),  rep(23));
        send(dc(-64), rep(-23), rep(-23), rep(-22));
        in_valid = 1'b0;
        drain();
        for (int d = 0; d < 3; d++)
            chk($sformatf("sat_clear_before_d%0d", d), 72'(osat[d]), 72'd0);

        // Saturation / wrap: 45*2047/128 = 719.6
        @(posedge clk); #1;
        send(dc(2047), rep(255), rep(207), rep(255));
        in_valid = 1'b0;
        drain();
        for (int d = 0; d < 3; d++)
            chk($sformatf("sat_set_d%0d", d), 72'(osat[d]), 72'd1);
        @(posedge clk); #1 sat_clr = 1'b1;
        @(posedge clk); #1 sat_clr = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("sat_cleared_d%0d", d), 72'(osat[d]), 72'd0);

        // Backpressure mid-stream
        @(posedge clk); #1;
        bp_chk = 1'b1;
        fork
            begin
                for (int s = 0; s < 12; s++) sendm(pat(100 + s));
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        bp_chk = 1'b0;
        chk("in_ready_dropped", 72'(ir_low > 0), 72'd1);

        // Reset with 2 rows in flight (15 rows delivered so far -> idx 7)
        @(posedge clk); #1 out_ready = 1'b0;
        sendm(pat(200));
        sendm(pat(201));
        in_valid = 1'b0;
        begin
            int n = 0;
            while (!ov[0] && n < 20) begin @(negedge clk); n++; end
        end
        chk("pre_reset_valid", 72'(ov[0]), 72'd1);
        chk("pre_reset_idx", 72'(oidx[0]), 72'd7);
        chk("pre_reset_last", 72'(olast[0]), 72'd1);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("mid_rst_valid_d%0d", d), 72'(ov[d]), 72'd0);
            chk($sformatf("mid_rst_idx_d%0d", d), 72'(oidx[d]), 72'd0);
        end
        chk("mid_rst_last", 72'(olast[0]), 72'd0);
        q0.delete(); q1.delete(); q2.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_valid", 72'(ov[0]), 72'd0);
        chk("post_rst_ready", 72'(irdy[0]), 72'd1);

        // Throughput: 16 back-to-back rows, idx 0..7,0..7
        @(posedge clk); #1;
        fork
            begin
                for (int s = 0; s < 16; s++) sendm(pat(s));
                in_valid = 1'b0;
            end
            begin
                lat = 0;
                run = 0;
                @(negedge clk);
                while (!ov[0] && lat < 20) begin lat++; @(negedge clk); end
                chk("first_idx_after_reset", 72'(oidx[0]), 72'd0);
                while (ov[0] && run < 40) begin run++; @(negedge clk); end
                chk("first_out_latency", 72'(lat), 72'd3);
                chk("valid_run_len", 72'(run), 72'd16);
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
